// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between two
// requesters, the arbiter and the external ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output busy
    );

    // Requesters plus the ALU.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC samples the ALU, RESP holds
// the result until the owning requester takes it.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic             id_r;
    logic             err_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic             busy_r;

    logic             grant0_s;
    logic             grant1_s;
    logic             ready0_s;
    logic             ready1_s;

    // True for the five opcodes the ALU implements.
    function automatic logic op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
        ready0_s = (state_r == IDLE) && grant0_s;
        ready1_s = (state_r == IDLE) && grant1_s;
    end

    // Arbitration FSM with captured operands and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            err_r        <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            op_r         <= 4'b0000;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ready0_s) begin
                        id_r    <= 1'b0;
                        a_r     <= bus.req0_a;
                        b_r     <= bus.req0_b;
                        // Illegal codes reach the ALU as AND so it never sees them.
                        op_r    <= op_legal(bus.req0_op) ? bus.req0_op : 4'b0000;
                        err_r   <= ~op_legal(bus.req0_op);
                        busy_r  <= 1'b1;
                        state_r <= EXEC;
                    end else if (ready1_s) begin
                        id_r    <= 1'b1;
                        a_r     <= bus.req1_a;
                        b_r     <= bus.req1_b;
                        op_r    <= op_legal(bus.req1_op) ? bus.req1_op : 4'b0000;
                        err_r   <= ~op_legal(bus.req1_op);
                        busy_r  <= 1'b1;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_result_r <= err_r ? {WIDTH{1'b0}} : bus.alu_result;
                    rsp_zero_r   <= err_r ? 1'b1 : bus.alu_zero;
                    rsp_err_r    <= err_r;
                    rsp0_valid_r <= ~id_r;
                    rsp1_valid_r <= id_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if ((rsp0_valid_r && bus.rsp0_ready) ||
                        (rsp1_valid_r && bus.rsp1_ready)) begin
                        last_grant_r <= id_r;
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.alu_a      = a_r;
    assign bus.alu_b      = b_r;
    assign bus.alu_op     = op_r;
    assign bus.busy       = busy_r;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 Port: reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 Port: reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-007 Port: reqN_op  input  4  opcode of requester N: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
REQ-008 Port: rspN_valid  output  1  result for requester N is presented.
REQ-009 Port: rspN_ready  input  1  requester N takes the result.
REQ-010 Port: rsp_result  output  WIDTH  registered result; shared by both response channels.
REQ-011 Port: rsp_zero  output  1  registered zero flag.
REQ-012 Port: rsp_err  output  1  opcode was not one of the five legal codes.
REQ-013 Port: alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-014 Port: alu_op  output  4  opcode to the shared ALU.
REQ-015 Port: alu_result  input  WIDTH  combinational ALU result.
REQ-016 Port: alu_zero  input  1  combinational ALU zero flag.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-019 In IDLE, the grant SHALL go to the only valid requester; if both are valid, it SHALL go to the requester not granted last (round-robin pointer last_grant).
REQ-020 reqN_ready SHALL be high only in IDLE and only for the granted N; it SHALL be combinational from reqN_valid and state.
REQ-021 On reqN_valid && reqN_ready, the arbiter SHALL capture a, b, op and the id N, then move to EXEC.
REQ-022 alu_a/alu_b/alu_op SHALL be driven only from the captured registers, never directly from the request ports.
REQ-023 An illegal opcode SHALL be captured with an err bit set; alu_op SHALL then be driven as 0000.
REQ-024 In EXEC (exactly one cycle), the arbiter SHALL register alu_result/alu_zero (or 0/1 if err), register err into rsp_err, and move to RESP.
REQ-025 In RESP, rspN_valid SHALL be high for the captured id only; rsp_result/rsp_zero/rsp_err SHALL be held stable.
REQ-026 On rspN_valid && rspN_ready, the arbiter SHALL set last_grant to id and return to IDLE; it SHALL accept no request in that cycle.
REQ-027 Latency SHALL be: handshake at edge T -> rspN_valid high in the cycle after edge T+1. Peak throughput SHALL be one operation per 3 cycles.
REQ-028 Requests arriving while busy SHALL wait with ready low; dropping reqN_valid before the handshake SHALL have no effect.
REQ-029 Arithmetic wraps modulo 2^WIDTH; no carry or overflow is reported.

Reset
REQ-030 While rst_n=0: state IDLE, last_grant=1 (req0 wins the first tie), all ready/valid outputs 0, rsp_result 0, rsp_zero 0, rsp_err 0, alu_a/alu_b 0, alu_op 0000, busy 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation without producing a response; after release the arbiter SHALL start in IDLE.

Verification
REQ-032 req0 a=5,b=3,op=0010, rsp0_ready=1 -> req0_ready=1 in cycle 0, rsp0_valid in cycle 2, rsp_result=8, rsp_zero=0, rsp_err=0.
REQ-033 Both valid after reset, both streams op=0110 with a=b=7 -> grants alternate 0,1,0,1; each result is 0 with zero=1.
REQ-034 req1 op=0011 -> alu_op=0000, rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-035 rsp0_ready held low for 5 cycles with req1 valid -> rsp0 values stable, req1_ready stays 0, req1 is granted in the cycle after the rsp0 handshake cycle.
REQ-036 rst_n pulsed low during EXEC -> no rspN_valid, all outputs at reset values, a new req0 op=0001 a=0xF0,b=0x0F gives rsp_result 0xFF.
REQ-037 a=0xFFFFFFFFFFFFFFFF, b=1, op=0010 -> rsp_result=0, rsp_zero=1.
